// File: rtl/sort_job_arbiter_pkg.sv
// Shared types and defaults for the sorter job arbiter.
// Everything that both the arbiter and its bus interface need to agree on lives here.
package sort_job_arbiter_pkg;

  localparam int W_DEF       = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int NVAL        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP,
    ST_DRAIN
  } state_t;

  // LSB of value k of requester req_idx inside the flat req_data bus
  function automatic int val_lsb(input int req_idx, input int k, input int w);
    return (req_idx * NVAL + k) * w;
  endfunction

endpackage

// File: rtl/sort_job_arbiter_if.sv
// Requester-side and sorter-side signals of the job arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface sort_job_arbiter_if
  import sort_job_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*NVAL*W-1:0] req_data;
  logic [NREQ-1:0]        grant;
  logic                   resp_valid;
  logic [IDW-1:0]         resp_id;
  logic [NVAL*W-1:0]      resp_data;
  logic                   resp_err;
  logic                   busy;

  logic [W-1:0]           srt_dataIn;
  logic [1:0]             srt_sel;
  logic                   srt_sort;
  logic                   srt_done;
  logic [W-1:0]           srt_A;
  logic [W-1:0]           srt_B;
  logic [W-1:0]           srt_C;
  logic [W-1:0]           srt_D;

  modport master (
    input  req, req_data, srt_done, srt_A, srt_B, srt_C, srt_D,
    output grant, resp_valid, resp_id, resp_data, resp_err, busy,
           srt_dataIn, srt_sel, srt_sort
  );

  modport slave (
    output req, req_data, srt_done, srt_A, srt_B, srt_C, srt_D,
    input  grant, resp_valid, resp_id, resp_data, resp_err, busy,
           srt_dataIn, srt_sel, srt_sort
  );

endinterface

// File: rtl/sort_job_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (wrapping) wins.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    // walk from farthest to nearest so the nearest active request is written last
    for (int k = NREQ - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr) + k) % NREQ;
      if (req[c]) begin
        idx = IDW'(c);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one four-value sorter between NREQ requesters: buffer, load, run with timeout, respond.
//   state    | meaning
//   IDLE     | waiting for any req; arbitrate, grant, capture job
//   LOAD     | present buffer[ld_cnt] on sel/dataIn, four cycles
//   RUN      | sort held high; wait done or timeout
//   RESP     | one-cycle response pulse
//   DRAIN    | sort low; wait for sorter done to clear (bounded)
module sort_job_arbiter
  import sort_job_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  sort_job_arbiter_if.master bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic [IDW-1:0]      ptr, ptr_nx;
  logic [IDW-1:0]      owner, owner_nx;
  logic [1:0]          ld_cnt, ld_cnt_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic [NVAL*W-1:0]   job_buf, job_buf_nx;

  logic [NREQ-1:0]     grant_q, grant_nx;
  logic                resp_valid_q, resp_valid_nx;
  logic [IDW-1:0]      resp_id_q, resp_id_nx;
  logic [NVAL*W-1:0]   resp_data_q, resp_data_nx;
  logic                resp_err_q, resp_err_nx;
  logic                busy_q, busy_nx;
  logic [1:0]          sel_q, sel_nx;
  logic [W-1:0]        din_q, din_nx;
  logic                sort_q, sort_nx;

  logic [NREQ-1:0]     win_gnt;
  logic [IDW-1:0]      win_idx;
  logic                win_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      ld_cnt       <= '0;
      timer        <= '0;
      job_buf      <= '0;
      grant_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= '0;
      din_q        <= '0;
      sort_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      owner        <= owner_nx;
      ld_cnt       <= ld_cnt_nx;
      timer        <= timer_nx;
      job_buf      <= job_buf_nx;
      grant_q      <= grant_nx;
      resp_valid_q <= resp_valid_nx;
      resp_id_q    <= resp_id_nx;
      resp_data_q  <= resp_data_nx;
      resp_err_q   <= resp_err_nx;
      busy_q       <= busy_nx;
      sel_q        <= sel_nx;
      din_q        <= din_nx;
      sort_q       <= sort_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    owner_nx      = owner;
    ld_cnt_nx     = ld_cnt;
    timer_nx      = timer;
    job_buf_nx    = job_buf;
    grant_nx      = '0;
    resp_valid_nx = 1'b0;
    resp_id_nx    = resp_id_q;
    resp_data_nx  = resp_data_q;
    resp_err_nx   = resp_err_q;
    sel_nx        = sel_q;
    din_nx        = din_q;
    sort_nx       = sort_q;

    unique case (state)
      ST_IDLE: begin
        if (win_any) begin
          grant_nx = win_gnt;
          owner_nx = win_idx;
          ptr_nx   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          for (int k = 0; k < NVAL; k++)
            job_buf_nx[k*W +: W] = bus.req_data[val_lsb(int'(win_idx), k, W) +: W];
          ld_cnt_nx = '0;
          sel_nx    = '0;
          din_nx    = bus.req_data[val_lsb(int'(win_idx), 0, W) +: W];
          state_nx  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (ld_cnt == 2'd3) begin
          sort_nx  = 1'b1;
          timer_nx = T_LOAD;
          state_nx = ST_RUN;
        end else begin
          ld_cnt_nx = ld_cnt + 2'd1;
          sel_nx    = ld_cnt_nx;
          din_nx    = job_buf[int'(ld_cnt_nx)*W +: W];
        end
      end

      ST_RUN: begin
        // a done that is already high on entry counts as completion
        if (bus.srt_done) begin
          resp_valid_nx = 1'b1;
          resp_id_nx    = owner;
          resp_data_nx  = {bus.srt_D, bus.srt_C, bus.srt_B, bus.srt_A};
          resp_err_nx   = 1'b0;
          sort_nx       = 1'b0;
          state_nx      = ST_RESP;
        end else if (timer == '0) begin
          resp_valid_nx = 1'b1;
          resp_id_nx    = owner;
          resp_data_nx  = '0;
          resp_err_nx   = 1'b1;
          sort_nx       = 1'b0;
          state_nx      = ST_RESP;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end

      ST_RESP: begin
        timer_nx = T_LOAD;
        state_nx = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (!bus.srt_done || timer == '0) state_nx = ST_IDLE;
        else timer_nx = timer - 1'b1;
      end

      default: state_nx = ST_IDLE;
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  assign bus.grant      = grant_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;
  assign bus.srt_sel    = sel_q;
  assign bus.srt_dataIn = din_q;
  assign bus.srt_sort   = sort_q;

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Bench for sort_job_arbiter: behavioural sorter model plus a response scoreboard.
module tb_sort_job_arbiter;
  import sort_job_arbiter_pkg::*;

  localparam int NREQ    = 2;
  localparam int W       = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 2;

  typedef struct {
    int               id;
    logic [4*W-1:0]   data;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sort_job_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  sort_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_seen = 0;
  int last_resp_cyc = 0;
  int grant_cyc = 0;
  int run_cyc = 0;
  exp_t exp_q[$];
  exp_t e_m;
  logic [W-1:0] vals [NREQ][4];

  bit never_done = 1'b0;
  int stale_hold = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] sort4(input logic [W-1:0] v [4]);
    logic [W-1:0] a [4];
    logic [W-1:0] t;
    for (int i = 0; i < 4; i++) a[i] = v[i];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // sorter model: loads while sort low, raises done LAT+1 cycles after sort rises
  logic [W-1:0]   mem [4];
  logic [4*W-1:0] srt_res;
  int lat_cnt;
  int stale_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.srt_done <= 1'b0;
      bus.srt_A <= '0; bus.srt_B <= '0; bus.srt_C <= '0; bus.srt_D <= '0;
      lat_cnt <= 0;
      stale_cnt <= 0;
    end else if (!bus.srt_sort) begin
      mem[bus.srt_sel] <= bus.srt_dataIn;
      lat_cnt <= 0;
      if (bus.srt_done) begin
        if (stale_cnt >= stale_hold) bus.srt_done <= 1'b0;
        else stale_cnt <= stale_cnt + 1;
      end
    end else begin
      stale_cnt <= 0;
      if (!never_done) begin
        if (lat_cnt == LAT) begin
          srt_res = sort4(mem);
          bus.srt_done <= 1'b1;
          bus.srt_A <= srt_res[W-1:0];
          bus.srt_B <= srt_res[2*W-1:W];
          bus.srt_C <= srt_res[3*W-1:2*W];
          bus.srt_D <= srt_res[4*W-1:3*W];
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      resp_seen++;
      last_resp_cyc = cyc;
      chk("resp_sort_low", bus.srt_sort, 0);
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", exp_q.size(), 1);
      end else begin
        e_m = exp_q.pop_front();
        chk("resp_id", bus.resp_id, e_m.id);
        chk("resp_data", bus.resp_data, e_m.data);
        chk("resp_err", bus.resp_err, e_m.err);
      end
    end
  end

  task automatic set_vals(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
    vals[id][0] = a; vals[id][1] = b; vals[id][2] = c; vals[id][3] = d;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 4; k++)
        bus.req_data[(i*4+k)*W +: W] = vals[i][k];
  endtask

  task automatic wait_grant(input int id, input bit drop, input bit scramble, input bit exp_err);
    logic [NREQ-1:0] g_exp;
    logic [W-1:0]    v [4];
    exp_t            e;
    int              n;
    g_exp = '0;
    g_exp[id] = 1'b1;
    for (int k = 0; k < 4; k++) v[k] = vals[id][k];
    n = 0;
    @(negedge clk);
    while (bus.grant == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    grant_cyc = cyc;
    chk("grant", bus.grant, g_exp);
    chk("busy_load", bus.busy, 1);
    e.id   = id;
    e.err  = exp_err;
    e.data = exp_err ? '0 : sort4(v);
    exp_q.push_back(e);
    if (drop) bus.req[id] = 1'b0;
    if (scramble) bus.req_data = ~bus.req_data;
    chk("sel0", bus.srt_sel, 0);
    chk("din0", bus.srt_dataIn, v[0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) chk("grant_pulse", bus.grant, 0);
      chk("sel", bus.srt_sel, k);
      chk("din", bus.srt_dataIn, v[k]);
      chk("sort_off_load", bus.srt_sort, 0);
    end
    @(negedge clk);
    chk("sort_on", bus.srt_sort, 1);
    run_cyc = cyc;
  endtask

  task automatic wait_resp();
    int target;
    int n;
    target = resp_seen + 1;
    n = 0;
    while (resp_seen < target && n < TIMEOUT + 40) begin
      @(posedge clk);
      n++;
    end
    chk("resp_arrived", resp_seen, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=done", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    bus.req = '0;
    bus.req_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_sort", bus.srt_sort, 0);
    chk("rst_sel_din", {bus.srt_sel, bus.srt_dataIn}, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_id, bus.resp_data}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // fairness: both requesting continuously
    set_vals(0, 4'h7, 4'h2, 4'hC, 4'h0);
    set_vals(1, 4'h5, 4'h5, 4'h1, 4'hE);
    drive_data();
    bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(j % 2, 1'b0, 1'b0, 1'b0);
      if (j > 0) chk("b2b_gap", grant_cyc - last_resp_cyc, 3);
      if (j == 3) bus.req = '0;
      wait_resp();
    end
    repeat (4) @(negedge clk);
    chk("idle_after_fair", bus.busy, 0);

    // single job with data changed right after grant
    set_vals(0, 4'h9, 4'h3, 4'hF, 4'h1);
    drive_data();
    bus.req = 2'b01;
    wait_grant(0, 1'b1, 1'b1, 1'b0);
    wait_resp();
    chk("done_lat", last_resp_cyc - run_cyc, LAT + 2);
    repeat (4) @(negedge clk);

    // timeout: sorter never completes
    never_done = 1'b1;
    set_vals(1, 4'hA, 4'h8, 4'h6, 4'h4);
    drive_data();
    bus.req = 2'b10;
    wait_grant(1, 1'b1, 1'b0, 1'b1);
    wait_resp();
    chk("timeout_lat", last_resp_cyc - run_cyc, TIMEOUT);
    repeat (3) @(negedge clk);
    chk("idle_after_to", bus.busy, 0);
    never_done = 1'b0;

    // stale done: sorter holds done after sort drops
    stale_hold = 3;
    set_vals(0, 4'hB, 4'h0, 4'hD, 4'h2);
    drive_data();
    bus.req = 2'b01;
    wait_grant(0, 1'b1, 1'b0, 1'b0);
    wait_resp();
    #1;
    set_vals(1, 4'h3, 4'hF, 4'h3, 4'h1);
    drive_data();
    bus.req = 2'b10;
    wait_grant(1, 1'b1, 1'b0, 1'b0);
    chk("stale_gap", grant_cyc - last_resp_cyc, 6);
    stale_hold = 0;
    wait_resp();
    repeat (4) @(negedge clk);

    // reset in the middle of RUN
    never_done = 1'b1;
    set_vals(0, 4'h1, 4'h2, 4'h3, 4'h4);
    drive_data();
    bus.req = 2'b01;
    wait_grant(0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    seen = resp_seen;
    rst = 1'b0;
    #1;
    chk("mid_rst_sort", bus.srt_sort, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.resp_valid, 0);
    exp_q.delete();
    never_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_resp_after_rst", resp_seen, seen);
    set_vals(0, 4'hE, 4'h6, 4'h0, 4'h8);
    set_vals(1, 4'h2, 4'h2, 4'h9, 4'h7);
    drive_data();
    bus.req = 2'b11;
    wait_grant(0, 1'b0, 1'b0, 1'b0);
    bus.req = '0;
    wait_resp();
    repeat (4) @(negedge clk);
    chk("final_idle", bus.busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_job_arbiter.md
# sort_job_arbiter

Round-robin scheduler that shares one four-entry nibble sorting engine (load via dataIn/sel, start via sort, completion via done) between NREQ independent requesters. Each accepted job is buffered, loaded into the sorter one value per cycle, started, watched with a timeout, and returned to its owner with a tagged response. Sits between the requester fabric and the sorter top level; the sorter itself is unchanged.

## Interface
- NREQ, 2: number of requesters (2..4).
- W, 4: value width; must match the sorter.
- TIMEOUT, 64: max cycles in RUN or DRAIN before abort.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester job request, level.
- req_data  in  NREQ*4*W  per requester four values; value k of requester i at [(i*4+k)*W +: W].
- grant  out  NREQ  one-hot, one-cycle pulse: job accepted, req_data sampled.
- resp_valid  out  1  one-cycle pulse: result available.
- resp_id  out  $clog2(NREQ)  owner of current response.
- resp_data  out  4*W  sorted values {A,B,C,D}, A at [W-1:0].
- resp_err  out  1  qualifies resp_valid: job aborted on timeout.
- busy  out  1  high in every state except IDLE.
- srt_dataIn  out  W  sorter load value.
- srt_sel  out  2  sorter load index.
- srt_sort  out  1  sorter start, level.
- srt_done  in  1  sorter completion, level.
- srt_A, srt_B, srt_C, srt_D  in  W each  sorter outputs.

## Operation
- States: IDLE, LOAD, RUN, RESP, DRAIN.
- IDLE: if any req, pick winner by round-robin from pointer ptr (search ptr, ptr+1, ... mod NREQ); same edge: grant[winner]=1 for one cycle, latch req_data slice into job buffer, latch owner id, ld_cnt=0, go LOAD. ptr updates to winner+1 mod NREQ.
- LOAD: drive srt_sel=ld_cnt, srt_dataIn=buffer[ld_cnt]; ld_cnt increments; after ld_cnt=3 go RUN. Exactly 4 cycles.
- RUN: srt_sort=1, timer counts. srt_done sampled 1 -> latch srt_A..D into resp_data, go RESP. Timer reaches TIMEOUT-1 without done -> resp_data=0, resp_err=1, go RESP.
- RESP: resp_valid=1 one cycle with resp_id=owner; srt_sort=0; go DRAIN.
- DRAIN: srt_sort=0; wait srt_done=0 (timer restarted, same TIMEOUT; expiry goes IDLE silently); then IDLE.
- req ignored outside IDLE; requester keeps req high to be re-arbitrated. Requester may drop req after its grant.
- Only one job in flight; no queue beyond the single job buffer.

## Timing
- Reset (rst=0, async): state IDLE, ptr=0, grant=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, srt_sel=0, srt_dataIn=0, srt_sort=0, timer=0.
- All outputs registered.
- req seen high at edge n -> grant at cycle n+1; LOAD cycles n+1..n+4 (sel 0,1,2,3); srt_sort high from n+5.
- srt_done high at edge m (in RUN) -> resp_valid at cycle m+1, srt_sort low from m+1.
- Minimum job-to-response: 6 cycles + sorter latency; back-to-back jobs separated by at least RESP+DRAIN+IDLE (3 cycles).
- Simultaneous req from all requesters: exactly one grant per IDLE visit; round-robin guarantees each waits at most NREQ-1 jobs.
- srt_done already high entering RUN (stale): treated as completion; DRAIN prevents this normally.
- Timer width $clog2(TIMEOUT); no wrap possible before abort.
- rst asserted mid-job: everything returns to reset values immediately; the in-flight job is lost, no response issued.

## Structure
- Shared package: state enum (IDLE, LOAD, RUN, RESP, DRAIN), W default, value-slice helper, TIMEOUT default.
- One sub-module: rr_arbiter (NREQ-wide round-robin pick given req and ptr, returns one-hot grant and index); FSM, buffer and timer in the top.

## Test plan
- Single job: req[0]=1, data {9,3,F,1} -> grant[0] one cycle, sel 0..3 with 9,3,F,1, sort high; sorter done -> resp_valid, resp_id=0, resp_data {1,3,9,F}, resp_err=0.
- Fairness: req=2'b11 held for 4 jobs -> grant order 0,1,0,1; ptr=0 after reset.
- Timeout: sorter model never raises done -> resp_valid with resp_err=1, resp_data=0 exactly TIMEOUT cycles after RUN entry, then IDLE.
- Stale done: model holds done high 3 cycles after sort drops -> no new LOAD until done low; next job correct.
- Reset mid-RUN: rst low during RUN -> srt_sort=0, busy=0 same cycle, no resp_valid; new req after release served normally.
- Data capture: requester changes req_data the cycle after grant -> loaded values are the sampled ones.
